// File: rtl/cnn_var_delay.sv
// Variable-delay line built on a ring of {valid, data} with a registered output.
// Define VAR_DELAY_FLUSH_EN to flush the ring and run a FILL phase on each delay change.
module cnn_var_delay #(
   parameter int DATA_WIDTH = 16,
   parameter int PTR_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] Data_In,
   input  logic                  valid_in,
   input  logic [PTR_WIDTH:0]    delay_cfg,
   input  logic                  cfg_load,
   output logic [DATA_WIDTH-1:0] Data_Out,
   output logic                  valid_out,
   output logic                  busy,
   output logic                  cfg_err
);

   localparam int MAX_DELAY = 2 ** PTR_WIDTH;
   localparam logic [PTR_WIDTH:0] D_MAX = (PTR_WIDTH+1)'(MAX_DELAY);
   localparam logic [PTR_WIDTH:0] D_ONE = (PTR_WIDTH+1)'(1);

   typedef enum logic {RUN, FILL} state_t;

   logic [DATA_WIDTH-1:0] mem_q [MAX_DELAY];
   logic [MAX_DELAY-1:0]  vld_q, vld_d;
   logic [PTR_WIDTH-1:0]  wp_q, wp_d, rd_addr;
   logic [PTR_WIDTH:0]    dly_q, dly_d;
   logic [PTR_WIDTH:0]    cnt_q, cnt_d;
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d, rdata;
   logic                  vout_q, vout_d;
   logic                  err_q, err_d;

   always_comb begin
      err_d = cfg_load && (delay_cfg == '0 || delay_cfg > D_MAX);
      dly_d = dly_q;
      if (cfg_load) begin
         if (delay_cfg == '0)
            dly_d = D_ONE;
         else if (delay_cfg > D_MAX)
            dly_d = D_MAX;
         else
            dly_d = delay_cfg;
      end

      wp_d = wp_q + PTR_WIDTH'(1);
      // Reading one slot past the write pointer makes the output flop the D-th stage.
      rd_addr = wp_q + PTR_WIDTH'(1) - dly_d[PTR_WIDTH-1:0];

      vld_d = vld_q;
`ifdef VAR_DELAY_FLUSH_EN
      if (cfg_load)
         vld_d = '0;
`endif
      vld_d[wp_q] = valid_in;

      vout_d = vld_q[rd_addr];
      rdata  = mem_q[rd_addr];
      if (dly_d == D_ONE) begin
         vout_d = valid_in;
         rdata  = Data_In;
      end
`ifdef VAR_DELAY_FLUSH_EN
      else if (cfg_load) begin
         vout_d = 1'b0;
      end
`endif
      dout_d = vout_d ? rdata : '0;

      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef VAR_DELAY_FLUSH_EN
      if (cfg_load) begin
         if (dly_d == D_ONE) begin
            state_d = RUN;
         end else begin
            state_d = FILL;
            cnt_d   = dly_d - D_ONE;
         end
      end else if (state_q == FILL) begin
         cnt_d = cnt_q - D_ONE;
         if (cnt_q == D_ONE)
            state_d = RUN;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q   <= '0;
         wp_q    <= '0;
         dly_q   <= D_MAX;
         cnt_q   <= '0;
         state_q <= RUN;
         dout_q  <= '0;
         vout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         vld_q   <= vld_d;
         wp_q    <= wp_d;
         dly_q   <= dly_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         dout_q  <= dout_d;
         vout_q  <= vout_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q[wp_q] <= Data_In;
   end

   assign Data_Out  = dout_q;
   assign valid_out = vout_q;
   assign cfg_err   = err_q;
`ifdef VAR_DELAY_FLUSH_EN
   assign busy = (state_q == FILL);
`else
   assign busy = 1'b0;
`endif

endmodule
